serdes_rx_ctrl: RTL and testbench
=================================

// Module: serdes_rx_ctrl
// PURPOSE
// Receive side of the 4-lane SerDes link fed by the DSP board's TX controller. Merges lanes into one 64-bit
// word, tracks the 3-word control preambles, and routes payload to two streams: M420 I/Q samples
// (re-geared from 64-bit words back to 48-bit samples via a small sync FIFO) and CFAR target records.
// Sits directly behind the GTX receive datapath on the master board, in the recovered-clock domain.
// PARAMETERS
// FIFO_AW     7     log2 depth of I/Q sample FIFO (128 x 48b); must absorb 1/3 of longest burst
// IDLE_WORD   16'hc5bc  per-lane idle pattern
// PORTS
// I_sys_clk            in   1   rx user clock (156.25 MHz), sole clock
// I_rst                in   1   async, active-high reset
// I_rx1..4_is_k        in   1   per-lane flag; high = payload word, low = control/idle word
// I_rx1..4_serdes_dat  in   16  lane data; word W = {rx4,rx3,rx2,rx1}
// I_clr_stat           in   1   sync clear of sticky flags and counters
// O_M420_result_ena    out  1   one I/Q sample valid
// O_M420_i_result_dat  out  24  I = sample[47:24]
// O_M420_q_result_dat  out  24  Q = sample[23:0]
// O_target_ena         out  1   one target record valid
// O_mode_info          out  3   W[47:45]
// O_angle_info         out  5   W[44:40]
// O_target_energy      out  24  W[39:16]
// O_target_range       out  13  W[12:0]
// O_link_state         out  3   current FSM state encoding
// O_fmt_err            out  1   one-cycle pulse on any format violation
// O_fifo_ovf           out  1   sticky: I/Q FIFO overflowed
// O_m420_frm_cnt, O_energy_frm_cnt, O_drop_cnt  out 16  statistics (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, gear phase=0, FIFO empty, sticky flags/counters 0.
// - Stage 0 registers lanes. Lane is_k disagreement -> word treated as control, O_fmt_err pulse.
// - Control word valid only if all four lanes equal: A=3c1c, B=3c3c, M=5c5c, E=7c7c, I=IDLE_WORD.
// - FSM: IDLE -A-> PA; PA -B-> PB, -A-> PA, else IDLE+err; PB -M-> RX_M420, -E-> RX_ENERGY,
//   else IDLE+err. RX_*: payload consumed; control A -> PA, I -> IDLE, other control -> IDLE+err.
// - Payload in IDLE/PA/PB: dropped, O_drop_cnt++, O_fmt_err pulse.
// - Entering RX_M420 clears gear phase p. Word by phase (S0..S3 = 48b samples):
//   p0: S0=W[63:16], hold W[15:0]; p1: S1={hold,W[63:32]}, hold W[31:0];
//   p2: S2={hold,W[63:48]}, S3=W[47:0]; p -> 0. p2 writes two samples same cycle.
// - Leaving RX_M420 with p!=0: held residue discarded, O_fmt_err pulse.
// - FIFO read one sample/cycle when non-empty; write with full -> sample dropped, O_fifo_ovf set.
//   Simultaneous 2-write with one free slot: S2 kept, S3 dropped, ovf set.
// - Latency: payload at lane pins cycle t -> O_target_ena at t+2; first I/Q sample of word at t+3.
// - RX_ENERGY: each payload word -> one record. W[63:48]!=0 or W[15:13]!=0 -> record still issued, err pulse.
// - Reset mid-frame: FIFO flushed, partial samples lost, FSM to IDLE on release.
// - I_clr_stat and an increment in same cycle: clear wins.
// CONFIGURATION
// SERDES_RX_STAT_EN defined: frame counters (inc on entering RX_M420/RX_ENERGY) and O_drop_cnt are
// 16-bit saturating at 16'hffff. Undefined: all three ports tied to 0, no counter logic.
// TESTING
// - Idle only (c5bc all lanes, is_k=0) 1000 cycles -> no ena, no err, state IDLE.
// - A,B,M + 3 payload words packing S0..S3 = 48'h000001..000004 -> 4 samples, I=0,Q=1..4, in order.
// - A,B,E + W=64'h0000_A5_123456_0_1FFF style record (mode 5, angle 5) -> O_target_ena at t+2, fields exact.
// - A,B,M + 2 words then I -> S0,S1 out, O_fmt_err pulse, state IDLE.
// - A,B,M + 384 continuous words (512 samples) with FIFO_AW=7 -> O_fifo_ovf=1, no deadlock, recovers.
// - Payload in IDLE x3 with SERDES_RX_STAT_EN -> O_drop_cnt=3; I_clr_stat -> 0.

Source files
------------

// File: rtl/serdes_rx_ctrl.sv
// serdes_rx_ctrl: 4-lane SerDes receive control; preamble FSM, 64->48b I/Q gearbox with sample FIFO, CFAR target records.
// Define SERDES_RX_STAT_EN to build the saturating frame/drop statistics counters.
module serdes_rx_ctrl #(
  parameter int FIFO_AW = 7,
  parameter logic [15:0] IDLE_WORD = 16'hc5bc
) (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_rx1_is_k,
  input  logic        I_rx2_is_k,
  input  logic        I_rx3_is_k,
  input  logic        I_rx4_is_k,
  input  logic [15:0] I_rx1_serdes_dat,
  input  logic [15:0] I_rx2_serdes_dat,
  input  logic [15:0] I_rx3_serdes_dat,
  input  logic [15:0] I_rx4_serdes_dat,
  input  logic        I_clr_stat,
  output logic        O_M420_result_ena,
  output logic [23:0] O_M420_i_result_dat,
  output logic [23:0] O_M420_q_result_dat,
  output logic        O_target_ena,
  output logic [2:0]  O_mode_info,
  output logic [4:0]  O_angle_info,
  output logic [23:0] O_target_energy,
  output logic [12:0] O_target_range,
  output logic [2:0]  O_link_state,
  output logic        O_fmt_err,
  output logic        O_fifo_ovf,
  output logic [15:0] O_m420_frm_cnt,
  output logic [15:0] O_energy_frm_cnt,
  output logic [15:0] O_drop_cnt
);
  typedef enum logic [2:0] {IDLE = 3'd0, PA = 3'd1, PB = 3'd2, RX_M420 = 3'd3, RX_ENERGY = 3'd4} state_t;
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] ONE = {{FIFO_AW{1'b0}}, 1'b1};
  logic [3:0] k_r;
  logic [63:0] w_r;
  state_t st, nxt;
  logic pl, mix, same, ca, cb, cm, ce, ci, bad, drop, gear, two, leave_res, rec_err;
  logic [1:0] ph;
  logic [31:0] hold;
  logic [47:0] s0, iq_q;
  logic [47:0] mem [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW:0] wp, rp, wp1, cnt, free;
  logic we0, we1, sdrop, rd;
  always_ff @(posedge I_sys_clk or posedge I_rst)
    if (I_rst) begin
      k_r <= '0;
      w_r <= '0;
    end else begin
      k_r <= {I_rx4_is_k, I_rx3_is_k, I_rx2_is_k, I_rx1_is_k};
      w_r <= {I_rx4_serdes_dat, I_rx3_serdes_dat, I_rx2_serdes_dat, I_rx1_serdes_dat};
    end
  // Any lane disagreement on is_k demotes the word to control.
  assign pl = &k_r;
  assign mix = |k_r && !pl;
  assign same = w_r[63:48] == w_r[47:32] && w_r[47:32] == w_r[31:16] && w_r[31:16] == w_r[15:0];
  assign ca = !pl && same && w_r[15:0] == 16'h3c1c;
  assign cb = !pl && same && w_r[15:0] == 16'h3c3c;
  assign cm = !pl && same && w_r[15:0] == 16'h5c5c;
  assign ce = !pl && same && w_r[15:0] == 16'h7c7c;
  assign ci = !pl && same && w_r[15:0] == IDLE_WORD;
  always_ff @(posedge I_sys_clk or posedge I_rst)
    if (I_rst) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    bad = 1'b0;
    drop = 1'b0;
    case (st)
      IDLE: begin
        drop = pl;
        nxt = ca ? PA : IDLE;
      end
      PA: begin
        drop = pl;
        bad = !ca && !cb;
        nxt = ca ? PA : cb ? PB : IDLE;
      end
      PB: begin
        drop = pl;
        bad = !cm && !ce;
        nxt = cm ? RX_M420 : ce ? RX_ENERGY : IDLE;
      end
      RX_M420, RX_ENERGY: begin
        bad = !pl && !ca && !ci;
        nxt = pl ? st : ca ? PA : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  assign gear = st == RX_M420 && pl;
  assign two = ph == 2'd2;
  assign leave_res = st == RX_M420 && nxt != RX_M420 && ph != 2'd0;
  assign rec_err = st == RX_ENERGY && pl && (|w_r[63:48] || |w_r[15:13]);
  assign s0 = ph == 2'd0 ? w_r[63:16] : ph == 2'd1 ? {hold[15:0], w_r[63:32]} : {hold, w_r[63:48]};
  // Gear phase only advances on payload in RX_M420; every other cycle discards residue.
  always_ff @(posedge I_sys_clk or posedge I_rst)
    if (I_rst) begin
      ph <= 2'd0;
      hold <= '0;
    end else if (gear) begin
      ph <= two ? 2'd0 : ph + 2'd1;
      hold <= ph == 2'd0 ? {16'h0, w_r[15:0]} : w_r[31:0];
    end else ph <= 2'd0;
  assign cnt = wp - rp;
  assign free = DEPTH - cnt;
  assign rd = cnt != '0;
  assign wp1 = wp + ONE;
  assign we0 = gear && free != '0;
  assign we1 = gear && two && free[FIFO_AW:1] != '0;
  assign sdrop = gear && !(two ? we1 : we0);
  always_ff @(posedge I_sys_clk) begin
    if (we0) mem[wp[FIFO_AW-1:0]] <= s0;
    if (we1) mem[wp1[FIFO_AW-1:0]] <= w_r[47:0];
  end
  always_ff @(posedge I_sys_clk or posedge I_rst)
    if (I_rst) begin
      wp <= '0;
      rp <= '0;
      O_M420_result_ena <= 1'b0;
      iq_q <= '0;
    end else begin
      wp <= wp + {{FIFO_AW{1'b0}}, we0} + {{FIFO_AW{1'b0}}, we1};
      rp <= rp + {{FIFO_AW{1'b0}}, rd};
      O_M420_result_ena <= rd;
      if (rd) iq_q <= mem[rp[FIFO_AW-1:0]];
    end
  assign O_M420_i_result_dat = iq_q[47:24];
  assign O_M420_q_result_dat = iq_q[23:0];
  always_ff @(posedge I_sys_clk or posedge I_rst)
    if (I_rst) begin
      O_target_ena <= 1'b0;
      O_mode_info <= '0;
      O_angle_info <= '0;
      O_target_energy <= '0;
      O_target_range <= '0;
      O_fmt_err <= 1'b0;
      O_fifo_ovf <= 1'b0;
    end else begin
      O_target_ena <= st == RX_ENERGY && pl;
      if (st == RX_ENERGY && pl) begin
        O_mode_info <= w_r[47:45];
        O_angle_info <= w_r[44:40];
        O_target_energy <= w_r[39:16];
        O_target_range <= w_r[12:0];
      end
      O_fmt_err <= mix || drop || bad || leave_res || rec_err;
      O_fifo_ovf <= I_clr_stat ? 1'b0 : O_fifo_ovf || sdrop;
    end
  assign O_link_state = st;
`ifdef SERDES_RX_STAT_EN
  logic enter_m, enter_e;
  assign enter_m = st == PB && nxt == RX_M420;
  assign enter_e = st == PB && nxt == RX_ENERGY;
  always_ff @(posedge I_sys_clk or posedge I_rst)
    if (I_rst || I_clr_stat) begin
      O_m420_frm_cnt <= '0;
      O_energy_frm_cnt <= '0;
      O_drop_cnt <= '0;
    end else begin
      if (enter_m && O_m420_frm_cnt != 16'hffff) O_m420_frm_cnt <= O_m420_frm_cnt + 16'd1;
      if (enter_e && O_energy_frm_cnt != 16'hffff) O_energy_frm_cnt <= O_energy_frm_cnt + 16'd1;
      if (drop && O_drop_cnt != 16'hffff) O_drop_cnt <= O_drop_cnt + 16'd1;
    end
`else
  assign O_m420_frm_cnt = '0;
  assign O_energy_frm_cnt = '0;
  assign O_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_serdes_rx_ctrl.sv
// tb_serdes_rx_ctrl: scoreboard bench for serdes_rx_ctrl; reference model packs payload as a bit stream.
module tb_serdes_rx_ctrl;
  localparam logic [15:0] IW = 16'hc5bc, CA = 16'h3c1c, CB = 16'h3c3c, CM = 16'h5c5c, CE = 16'h7c7c;
  localparam int DEPTH = 128;
  logic clk = 0, rst = 1, clr = 0;
  logic k1 = 0, k2 = 0, k3 = 0, k4 = 0;
  logic [15:0] d1 = IW, d2 = IW, d3 = IW, d4 = IW;
  logic iq_ena, tgt_ena, fmt_err, fifo_ovf;
  logic [23:0] i_dat, q_dat, energy;
  logic [2:0] mode, lstate;
  logic [4:0] angle;
  logic [12:0] range_o;
  logic [15:0] m_cnt, e_cnt, d_cnt;
  serdes_rx_ctrl dut (
    .I_sys_clk(clk), .I_rst(rst),
    .I_rx1_is_k(k1), .I_rx2_is_k(k2), .I_rx3_is_k(k3), .I_rx4_is_k(k4),
    .I_rx1_serdes_dat(d1), .I_rx2_serdes_dat(d2), .I_rx3_serdes_dat(d3), .I_rx4_serdes_dat(d4),
    .I_clr_stat(clr),
    .O_M420_result_ena(iq_ena), .O_M420_i_result_dat(i_dat), .O_M420_q_result_dat(q_dat),
    .O_target_ena(tgt_ena), .O_mode_info(mode), .O_angle_info(angle),
    .O_target_energy(energy), .O_target_range(range_o),
    .O_link_state(lstate), .O_fmt_err(fmt_err), .O_fifo_ovf(fifo_ovf),
    .O_m420_frm_cnt(m_cnt), .O_energy_frm_cnt(e_cnt), .O_drop_cnt(d_cnt)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [63:0] v; int c;} exp_t;
  exp_t sq[$], tq[$];
  bit exp_err[int];
  logic [2:0] exp_st[int];
  logic [47:0] mq[$], pend[$];
  logic [127:0] rb = '0;
  int mst = 0, nb = 0, mc = 0, ec = 0, dc = 0;
  bit m_ovf = 0, run = 0;
  int nchk = 0, nerr = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Reference model: sees each lane word at the negedge before it is captured.
  always @(negedge clk) begin : model
    logic [3:0] k;
    logic [63:0] w;
    logic [15:0] v;
    bit pl, e;
    int nxt, free, n;
    if (run) begin
      n = cyc;
      free = DEPTH - mq.size();
      if (mq.size() > 0) sq.push_back('{{16'h0, mq.pop_front()}, n + 1});
      foreach (pend[i])
        if (free > 0) begin
          mq.push_back(pend[i]);
          free--;
        end else m_ovf = 1;
      pend.delete();
      if (clr) begin
        m_ovf = 0; mc = 0; ec = 0; dc = 0;
      end
      k = {k4, k3, k2, k1};
      w = {d4, d3, d2, d1};
      pl = k == 4'hf;
      e = k != 4'h0 && !pl;
      v = (w[63:48] == w[47:32] && w[47:32] == w[31:16] && w[31:16] == w[15:0]) ? w[15:0] : 16'h0;
      nxt = mst;
      if (pl && mst < 3) begin
        e = 1;
        if (dc < 65535) dc++;
        nxt = 0;
      end else if (mst == 0) begin
        if (v == CA) nxt = 1;
      end else if (mst == 1) begin
        if (v == CA) nxt = 1;
        else if (v == CB) nxt = 2;
        else begin nxt = 0; e = 1; end
      end else if (mst == 2) begin
        if (v == CM) begin
          nxt = 3; nb = 0;
          if (mc < 65535) mc++;
        end else if (v == CE) begin
          nxt = 4;
          if (ec < 65535) ec++;
        end else begin nxt = 0; e = 1; end
      end else if (pl && mst == 3) begin
        rb = (rb << 64) | {64'h0, w};
        nb += 64;
        while (nb >= 48) begin
          pend.push_back(48'(rb >> (nb - 48)));
          nb -= 48;
        end
      end else if (pl) begin
        tq.push_back('{{19'h0, w[47:40], w[39:16], w[12:0]}, n + 2});
        if (w[63:48] != 0 || w[15:13] != 0) e = 1;
      end else begin
        nxt = (v == CA) ? 1 : 0;
        if (v != CA && v != IW) e = 1;
        if (mst == 3 && nb != 0) e = 1;
        nb = 0;
      end
      exp_err[n + 2] = e;
      mst = nxt;
      exp_st[n + 2] = 3'(nxt);
    end
  end
  always @(negedge clk) begin : monitor
    exp_t x;
    if (run) begin
      if (exp_err.exists(cyc)) chk("fmt_err", {63'h0, fmt_err}, {63'h0, exp_err[cyc]});
      if (exp_st.exists(cyc)) chk("link_state", {61'h0, lstate}, {61'h0, exp_st[cyc]});
      if (iq_ena) begin
        if (sq.size() == 0) chk("iq_unexpected", {63'h0, iq_ena}, 64'h0);
        else begin
          x = sq.pop_front();
          chk("iq_data", {16'h0, i_dat, q_dat}, x.v);
          chk("iq_latency", 64'(cyc), 64'(x.c));
        end
      end
      if (tgt_ena) begin
        if (tq.size() == 0) chk("tgt_unexpected", {63'h0, tgt_ena}, 64'h0);
        else begin
          x = tq.pop_front();
          chk("tgt_fields", {19'h0, mode, angle, energy, range_o}, x.v);
          chk("tgt_latency", 64'(cyc), 64'(x.c));
        end
      end
    end
  end
  task automatic put(input logic [3:0] k, input logic [63:0] w);
    @(posedge clk);
    #1;
    {k4, k3, k2, k1} = k;
    {d4, d3, d2, d1} = w;
  endtask
  task automatic idle(input int n);
    repeat (n) put(4'h0, {4{IW}});
  endtask
  task automatic ctl(input logic [15:0] c);
    put(4'h0, {4{c}});
  endtask
  task automatic pay(input logic [63:0] w);
    put(4'hf, w);
  endtask
  task automatic rnd_pay();
    pay({$urandom, $urandom});
  endtask
  task automatic term();
    case ($urandom_range(0, 3))
      0: ctl(IW);
      1: ctl(CA);
      2: put(4'h0, 64'h1111_2222_3333_4444);
      default: put(4'b0011, {4{IW}});
    endcase
  endtask
  task automatic clear();
    @(posedge clk);
    #1 clr = 1;
    @(posedge clk);
    #1 clr = 0;
  endtask
  task automatic quiet(input string tag);
    idle(20);
    chk({tag, "_ovf"}, {63'h0, fifo_ovf}, {63'h0, m_ovf});
`ifdef SERDES_RX_STAT_EN
    chk({tag, "_m420_cnt"}, {48'h0, m_cnt}, 64'(mc));
    chk({tag, "_energy_cnt"}, {48'h0, e_cnt}, 64'(ec));
    chk({tag, "_drop_cnt"}, {48'h0, d_cnt}, 64'(dc));
`else
    chk({tag, "_m420_cnt"}, {48'h0, m_cnt}, 64'h0);
    chk({tag, "_energy_cnt"}, {48'h0, e_cnt}, 64'h0);
    chk({tag, "_drop_cnt"}, {48'h0, d_cnt}, 64'h0);
`endif
  endtask
  initial begin
    logic [191:0] bs;
    logic [63:0] w;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {61'h0, lstate}, 64'h0);
    chk("reset_outs", {60'h0, iq_ena, tgt_ena, fmt_err, fifo_ovf}, 64'h0);
    rst = 0;
    run = 1;
    idle(1000);
    quiet("idle");
    bs = {48'h1, 48'h2, 48'h3, 48'h4};
    ctl(CA); ctl(CB); ctl(CM);
    pay(bs[191:128]); pay(bs[127:64]); pay(bs[63:0]);
    ctl(IW);
    quiet("m420");
    ctl(CA); ctl(CB); ctl(CE);
    pay(64'h0000_A512_3456_1FFF);
    ctl(IW);
    quiet("energy");
    ctl(CA); ctl(CB); ctl(CM);
    rnd_pay(); rnd_pay();
    ctl(IW);
    quiet("residue");
    ctl(CA); ctl(CB); ctl(CM);
    repeat (480) rnd_pay();
    ctl(IW);
    idle(300);
    quiet("ovf");
    chk("ovf_seen", {63'h0, fifo_ovf}, 64'h1);
    clear();
    quiet("ovf_clr");
    ctl(CA); ctl(CB); ctl(CM);
    repeat (6) rnd_pay();
    ctl(IW);
    quiet("recover");
    put(4'b0101, {4{IW}});
    quiet("mixk");
    clear();
    repeat (3) rnd_pay();
    quiet("drop3");
    clear();
    quiet("drop_clr");
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          ctl(CA); ctl(CB); ctl(CM);
          repeat ($urandom_range(1, 20)) rnd_pay();
          term();
        end
        1: begin
          ctl(CA); ctl(CB); ctl(CE);
          repeat ($urandom_range(1, 6)) begin
            w = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) begin
              w[63:48] = 16'h0;
              w[15:13] = 3'h0;
            end
            pay(w);
          end
          term();
        end
        2: repeat ($urandom_range(1, 3)) rnd_pay();
        3: begin ctl(CA); ctl(16'h1234); end
        4: begin
          ctl(CA); ctl(CA); ctl(CB); ctl(CM);
          repeat (3) rnd_pay();
          term();
        end
        default: put(4'($urandom_range(1, 14)), {4{IW}});
      endcase
      idle(3);
    end
    idle(30);
    quiet("final");
    chk("iq_pending", 64'(sq.size()), 64'h0);
    chk("tgt_pending", 64'(tq.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
